// File: rtl/serial_alu_exec.sv
// serial_alu_exec: slice-serial ALU for the multi-cycle EX stage.
// Executes one alu_control operation over WIDTH/SLICE cycles under a
// start/busy/done handshake. The controller holds the stage until done.
// Optional build macro: SERIAL_ALU_LOGIC_BYPASS_EN -- when defined, AND/OR/XOR
// and illegal codes finish in a single RUN cycle using a full-width bitwise op.
module serial_alu_exec #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  // Guarded so a bad SLICE does not trip a divide-by-zero before the check fires
  localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
  localparam int N          = WIDTH / SLICE_SAFE;
  localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE_SAFE) != 0)) begin : g_bad_param
      $error("serial_alu_exec: SLICE must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // SUB and SLT both compute a + ~b + 1
  function automatic logic f_is_sub(input logic [3:0] op);
    f_is_sub = (op == OP_SUB) || (op == OP_SLT);
  endfunction

`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
  // Operations that can finish in one cycle: everything except the arithmetic ones
  function automatic logic f_is_fast(input logic [3:0] op);
    f_is_fast = !((op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT));
  endfunction
`endif

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;

  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;

  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_b_eff;
  logic [SLICE:0]     w_sum_ext;
  logic               w_cout;
  logic               w_cin_msb;
  logic               w_ovf_raw;
  logic [SLICE-1:0]   w_slice_res;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_final;
  logic               w_final_ovf;
  logic               w_final_ill;
`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
  logic [WIDTH-1:0]   w_logic_full;
`endif

  assign w_accept = start && (r_state != S_RUN);

  // Last RUN cycle: final slice, or the single-cycle logic path when enabled
  always_comb begin
    w_last = (r_cnt == CNT_LAST);
`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
    if (f_is_fast(r_op)) begin
      w_last = 1'b1;
    end else begin
      w_last = (r_cnt == CNT_LAST);
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state logic; DONE can accept directly for back-to-back operation
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nx = S_RUN;
        else          w_state_nx = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nx = S_DONE;
        else        w_state_nx = S_RUN;
      end
      S_DONE: begin
        if (w_accept) w_state_nx = S_RUN;
        else          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM outputs, registered from the next state so busy/done are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == S_RUN);
      r_done <= (w_state_nx == S_DONE);
    end
  end

  // Current slice: operands are shifted right so the active slice is always at the bottom
  always_comb begin
    w_a_sl    = r_a[SLICE-1:0];
    w_b_eff   = f_is_sub(r_op) ? ~r_b[SLICE-1:0] : r_b[SLICE-1:0];
    w_sum_ext = {1'b0, w_a_sl} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, r_carry};
    w_cout    = w_sum_ext[SLICE];
    // Carry into the top bit recovered from that bit's sum and inputs
    w_cin_msb = w_sum_ext[SLICE-1] ^ w_a_sl[SLICE-1] ^ w_b_eff[SLICE-1];
    w_ovf_raw = w_cin_msb ^ w_cout;
    case (r_op)
      OP_AND:  w_slice_res = w_a_sl & r_b[SLICE-1:0];
      OP_OR:   w_slice_res = w_a_sl | r_b[SLICE-1:0];
      OP_XOR:  w_slice_res = w_a_sl ^ r_b[SLICE-1:0];
      OP_ADD:  w_slice_res = w_sum_ext[SLICE-1:0];
      OP_SUB:  w_slice_res = w_sum_ext[SLICE-1:0];
      OP_SLT:  w_slice_res = w_sum_ext[SLICE-1:0];
      default: w_slice_res = {SLICE{1'b0}};
    endcase
    // New slice enters at the top; after N cycles slice 0 has reached bit 0
    w_acc_next = (r_acc >> SLICE) | (WIDTH'(w_slice_res) << (WIDTH - SLICE));
  end

`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
  // Full-width bitwise result for the single-cycle logic path
  always_comb begin
    case (r_op)
      OP_AND:  w_logic_full = r_a & r_b;
      OP_OR:   w_logic_full = r_a | r_b;
      OP_XOR:  w_logic_full = r_a ^ r_b;
      default: w_logic_full = {WIDTH{1'b0}};
    endcase
  end
`endif

  // Final result and flags, meaningful only in the last RUN cycle
  always_comb begin
    w_final     = {WIDTH{1'b0}};
    w_final_ovf = 1'b0;
    w_final_ill = 1'b0;
    case (r_op)
      OP_AND, OP_OR, OP_XOR: begin
`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
        w_final = w_logic_full;
`else
        w_final = w_acc_next;
`endif
      end
      OP_ADD, OP_SUB: begin
        w_final     = w_acc_next;
        w_final_ovf = w_ovf_raw;
      end
      OP_SLT: begin
        // Signed less-than: sign of (a-b) corrected by its overflow
        w_final = WIDTH'(w_sum_ext[SLICE-1] ^ w_ovf_raw);
      end
      default: begin
        w_final_ill = 1'b1;
      end
    endcase
  end

  // Operand capture on accept, then per-slice shift, carry and counter in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_op    <= 4'b0000;
      r_carry <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= alu_control;
      r_carry <= f_is_sub(alu_control);
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> SLICE;
      r_b     <= r_b >> SLICE;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_acc   <= w_acc_next;
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_op    <= r_op;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
      r_acc   <= r_acc;
    end
  end

  // Visible result/flags load only when the operation completes, then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= {WIDTH{1'b0}};
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_result   <= w_final;
      r_zero     <= ~|w_final;
      r_overflow <= w_final_ovf;
      r_illegal  <= w_final_ill;
    end else begin
      r_result   <= r_result;
      r_zero     <= r_zero;
      r_overflow <= r_overflow;
      r_illegal  <= r_illegal;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_overflow;
  assign illegal  = r_illegal;

endmodule
